logic_gate_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the registered, multi-bit, multi-function successor of the single-bit gate primitives. It applies one of eight selectable bitwise operations to two WIDTH-bit operands and registers the result behind a valid/ready handshake. It provides reduction flags, an accumulate mode that chains results through an internal register, and a wrapping transaction counter. It sits between an operand producer and a result consumer in streaming datapaths.

---
 rtl/logic_gate_pipe.sv | 137 +++++++++++++
 tb/tb_logic_gate_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - pipelined multi-function bitwise logic unit with accumulator
//
// Applies one of eight bitwise operations to two WIDTH-bit operands and
// holds the result in an output register behind a valid/ready handshake.
// When acc_mode is set, the internal accumulator takes the place of
// operand B and the result is written back into the accumulator.
//
// Parameters:
//   WIDTH     operand/result width in bits (1..64)
//   CNT_W     width of the wrapping accepted-beat counter
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   in_valid    operand beat present
//   in_ready    unit can accept a beat (depends only on out_valid/out_ready)
//   a, b        operands; b is ignored in accumulate mode
//   op          operation select, sampled with the beat
//   acc_mode    use acc as operand B and write the result back into acc
//   acc_clr     clear acc; honoured every cycle, with or without a beat
//   out_valid   result beat present
//   out_ready   consumer accepts the result
//   y           registered result
//   y_any       OR-reduction of y
//   y_all       AND-reduction of y
//   acc         accumulator contents
//   txn_count   number of accepted input beats, wraps silently

module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_any,
    output logic             y_all,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] txn_count
);

    // Operation encodings
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_BUF  = 3'b111;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] f;

    // The output register can take a new beat when it is empty or is being
    // drained this very cycle, which gives one beat per clock under no
    // backpressure. Deliberately independent of in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // Effective operand B. A clear that arrives together with an
    // accumulate beat means "start a fresh chain", so the beat sees zero
    // instead of the stale accumulator.
    always_comb begin
        b_eff = b;
        if (acc_mode) begin
            b_eff = acc_clr ? '0 : acc;
        end
    end

    always_comb begin
        f = '0;
        case (op)
            OP_AND:  f = a & b_eff;
            OP_OR:   f = a | b_eff;
            OP_XOR:  f = a ^ b_eff;
            OP_NAND: f = ~(a & b_eff);
            OP_NOR:  f = ~(a | b_eff);
            OP_XNOR: f = ~(a ^ b_eff);
            OP_NOT:  f = ~a;
            OP_BUF:  f = a;
            default: f = '0;
        endcase
    end

    // Output register: loads on accept (also when a consume happens in the
    // same cycle), drops valid only after a consume with no new beat, and
    // otherwise holds everything stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_any     <= 1'b0;
            y_all     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= f;
            y_any     <= |f;
            y_all     <= &f;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator. An accumulate beat writes its result (which already
    // reflects acc_clr through b_eff); otherwise acc_clr clears whether or
    // not a beat is accepted, so a standalone clear needs no handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && acc_mode) begin
            acc <= f;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (accept) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - scoreboard testbench for logic_gate_pipe

module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       acc_mode = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic       y_any;
    logic       y_all;
    logic [7:0] acc;
    logic [3:0] txn_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic       m_ov;
    logic [7:0] m_acc;
    logic [3:0] m_cnt;

    logic [7:0] tt_exp[8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_any(y_any), .y_all(y_all),
        .acc(acc), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gate_fn(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle when inputs and
    // outputs are stable; predicts the effect of the coming rising edge.
    always @(negedge clk) begin
        logic [7:0] bb, f, e;
        logic       m_ready, accept, consume;
        if (rst) begin
            m_ov  = 1'b0;
            m_acc = '0;
            m_cnt = '0;
            exp_q.delete();
        end else begin
            m_ready = !m_ov || out_ready;
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_ov);
            chk("acc", acc, m_acc);
            chk("txn_count", txn_count, m_cnt);
            consume = out_valid && out_ready;
            if (consume) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_y", y, e);
                    chk("sb_y_any", y_any, |e);
                    chk("sb_y_all", y_all, &e);
                end
            end
            accept = in_valid && m_ready;
            bb = acc_mode ? (acc_clr ? 8'h00 : m_acc) : b;
            f  = gate_fn(op, a, bb);
            if (accept) begin
                exp_q.push_back(f);
                m_cnt = m_cnt + 4'd1;
                m_ov  = 1'b1;
                if (acc_mode)     m_acc = f;
                else if (acc_clr) m_acc = '0;
            end else begin
                if (consume) m_ov = 1'b0;
                if (acc_clr) m_acc = '0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Idle cycle inputs: operands are scrambled to show they are ignored.
    task automatic idle();
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        op       = 3'($urandom);
        acc_mode = 1'($urandom);
        acc_clr  = 1'b0;
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                        input logic tam, input logic tac);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        op       = top;
        acc_mode = tam;
        acc_clr  = tac;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        out_ready = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_y_any", y_any, 0);
        chk("rst_y_all", y_all, 0);
        chk("rst_acc", acc, 0);
        chk("rst_cnt", txn_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Truth table, full throughput
        for (int i = 0; i < 8; i++) begin
            send(8'hF0, 8'hCC, 3'(i), 1'b0, 1'b0);
            chk("tt_y", y, tt_exp[i]);
            chk("tt_valid", out_valid, 1);
            chk("tt_any", y_any, 1);
            chk("tt_all", y_all, 0);
        end
        idle();
        step(2);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                send(8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
                send(8'h0F, 8'hF0, 3'd2, 1'b0, 1'b0);
                send(8'hAA, 8'h55, 3'd0, 1'b0, 1'b0);
                idle();
            end
            begin
                step(3);
                chk("bp_ready", in_ready, 0);
                chk("bp_hold_y", y, 8'h33);
                chk("bp_cnt", txn_count, 1);
                out_ready = 1'b1;
            end
        join
        step(3);
        chk("bp_cnt_final", txn_count, 3);
        chk("bp_drained", out_valid, 0);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Accumulate chain with back-to-back beats
        do_reset();
        out_ready = 1'b1;
        send(8'h01, 8'hEE, 3'd1, 1'b1, 1'b1);
        chk("acc_1", acc, 8'h01);
        chk("acc_y1", y, 8'h01);
        send(8'h04, 8'hEE, 3'd1, 1'b1, 1'b0);
        chk("acc_2", acc, 8'h05);
        send(8'h80, 8'hEE, 3'd1, 1'b1, 1'b0);
        chk("acc_3", acc, 8'h85);
        chk("acc_y3", y, 8'h85);
        send(8'hFF, 8'hEE, 3'd2, 1'b1, 1'b0);
        chk("acc_xor", acc, 8'h7A);
        chk("acc_y_xor", y, 8'h7A);
        send(8'h85, 8'h00, 3'd7, 1'b1, 1'b0);
        out_ready = 1'b0;
        // Standalone clear while the result is held
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        step(1);
        idle();
        chk("clr_acc", acc, 0);
        chk("clr_y", y, 8'h85);
        chk("clr_valid", out_valid, 1);
        chk("clr_cnt", txn_count, 5);
        out_ready = 1'b1;
        step(2);

        // Counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        end
        idle();
        step(2);
        chk("wrap_cnt", txn_count, 1);

        // Asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b0;
        send(8'h3C, 8'h00, 3'd7, 1'b1, 1'b0);
        idle();
        chk("ar_pre_valid", out_valid, 1);
        chk("ar_pre_acc", acc, 8'h3C);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_y", y, 0);
        chk("ar_any", y_any, 0);
        chk("ar_all", y_all, 0);
        chk("ar_acc", acc, 0);
        chk("ar_cnt", txn_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(8'hF0, 8'hCC, 3'd0, 1'b0, 1'b0);
        chk("ar_post_valid", out_valid, 1);
        chk("ar_post_y", y, 8'hC0);
        chk("ar_post_cnt", txn_count, 1);
        idle();
        step(3);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
